// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with configurable bit time, optional parity and 1/2 stop bits
module uart_tx #(
    parameter int CLKS_PER_BIT = 2,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_line,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START_BIT  = 3'd1;
    localparam logic [2:0] DATA_BITS  = 3'd2;
    localparam logic [2:0] PARITY_BIT = 3'd3;
    localparam logic [2:0] STOP_BIT   = 3'd4;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam bit PAR_EN   = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD  = (PARITY == 2);
    localparam bit TWO_STOP = (STOP_BITS == 2);

    logic [2:0]  state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        par_bit;
    logic        stop_idx;
    logic        bit_end;

    assign bit_end = (bit_cnt == BIT_LAST);

    // tx_line is driven one edge ahead so the line value always matches the registered state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_idx <= 1'b0;
            tx_line  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_line <= 1'b1;
                    busy    <= 1'b0;
                    if (tx_start) begin
                        shreg    <= tx_data;
                        par_bit  <= (^tx_data) ^ PAR_ODD;
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        state    <= START_BIT;
                        tx_line  <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= DATA_BITS;
                        tx_line <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA_BITS: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (PAR_EN) begin
                                state   <= PARITY_BIT;
                                tx_line <= par_bit;
                            end else begin
                                state   <= STOP_BIT;
                                tx_line <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_line <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                PARITY_BIT: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= STOP_BIT;
                        tx_line <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                STOP_BIT: begin
                    tx_line <= 1'b1;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (TWO_STOP && !stop_idx) begin
                            stop_idx <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_line <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
